m_store_seq_pack: RTL and testbench

//  Matrix store datapath back end, the write-side counterpart of the matrix load path.
//  - Takes deshuffled, byte-sequential buffer entries from the store shuffle stage.
//  - Repacks them into AXI W beats: applies the address-offset rotation and builds

---
 rtl/mlsu_pkg.sv | 29 ++
 rtl/m_store_entry_fifo.sv | 67 ++++++
 rtl/m_store_seq_pack.sv | 164 ++++++++++++++++
 tb/tb_m_store_seq_pack.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlsu_pkg.sv
// Shared types and size helpers for the matrix load/store unit.
package mlsu_pkg;

    localparam int DEF_AXI_DATA_W  = 128;
    localparam int DEF_BUF_W       = 512;
    localparam int DEF_TXN_BYTES_W = 16;

    function automatic int bus_bytes(input int axi_data_w);
        return axi_data_w / 8;
    endfunction

    function automatic int buf_bytes(input int buf_w);
        return buf_w / 8;
    endfunction

    localparam int DEF_OFF_W = $clog2(bus_bytes(DEF_AXI_DATA_W));

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } store_state_e;

    typedef struct packed {
        logic [DEF_OFF_W-1:0]       off;
        logic [DEF_TXN_BYTES_W-1:0] bytes;
        logic [7:0]                 len;
    } txn_ctrl_t;

endpackage

// File: rtl/m_store_entry_fifo.sv
// Two-slot (cur, nxt) holding buffer for byte-sequential store entries.
// Retire frees 0, 1 or 2 slots; a same-cycle push lands in the first free slot.
module m_store_entry_fifo #(
    parameter int Width = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    input  logic [1:0]       retire,
    output logic             cur_valid,
    output logic [Width-1:0] cur_data,
    output logic             nxt_valid,
    output logic [Width-1:0] nxt_data
);

    logic             cur_v_d, nxt_v_d;
    logic [Width-1:0] cur_d_d, nxt_d_d;
    logic             push;

    assign in_ready = !nxt_valid;
    assign push     = in_valid && !nxt_valid;

    always_comb begin
        cur_v_d = cur_valid;
        cur_d_d = cur_data;
        nxt_v_d = nxt_valid;
        nxt_d_d = nxt_data;
        case (retire)
            2'd1: begin
                cur_v_d = nxt_valid;
                cur_d_d = nxt_data;
                nxt_v_d = 1'b0;
            end
            2'd2, 2'd3: begin
                cur_v_d = 1'b0;
                nxt_v_d = 1'b0;
            end
            default: ;
        endcase
        if (push) begin
            if (!cur_v_d) begin
                cur_v_d = 1'b1;
                cur_d_d = in_data;
            end else begin
                nxt_v_d = 1'b1;
                nxt_d_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            cur_data  <= '0;
            nxt_data  <= '0;
        end else begin
            cur_valid <= cur_v_d;
            nxt_valid <= nxt_v_d;
            cur_data  <= cur_d_d;
            nxt_data  <= nxt_d_d;
        end
    end

endmodule

// File: rtl/m_store_seq_pack.sv
// Matrix store back end: repacks byte-sequential entries into rotated AXI W beats.
// state     | meaning
// ST_IDLE   | no burst open, waiting for a descriptor
// ST_ACTIVE | emitting beats of the current burst
module m_store_seq_pack
    import mlsu_pkg::*;
#(
    parameter int AxiDataWidth = DEF_AXI_DATA_W,
    parameter int BufWidth     = DEF_BUF_W,
    parameter int TxnBytesW    = DEF_TXN_BYTES_W
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    txn_ctrl_valid_i,
    output logic                                    txn_ctrl_ready_o,
    input  logic [$clog2(AxiDataWidth/8)-1:0]       txn_off_i,
    input  logic [TxnBytesW-1:0]                    txn_bytes_i,
    input  logic [7:0]                              txn_len_i,
    input  logic                                    rx_valid_i,
    output logic                                    rx_ready_o,
    input  logic [BufWidth-1:0]                     rx_data_i,
    output logic                                    axi_w_valid_o,
    input  logic                                    axi_w_ready_i,
    output logic [AxiDataWidth-1:0]                 axi_w_data_o,
    output logic [AxiDataWidth/8-1:0]               axi_w_strb_o,
    output logic                                    axi_w_last_o,
    output logic                                    store_done_o
);

    localparam int BusBytes = bus_bytes(AxiDataWidth);
    localparam int BufBytes = buf_bytes(BufWidth);
    localparam int OffW     = $clog2(BusBytes);
    localparam int NbW      = OffW + 1;
    localparam int PtrW     = $clog2(BufBytes) + 1;

    store_state_e state_q, state_d;
    txn_ctrl_t    txn_in;

    logic [OffW-1:0]      off_q;
    logic [TxnBytesW-1:0] rem_q;
    logic [8:0]           beats_q;
    logic [PtrW-1:0]      ptr_q;
    logic                 first_q;
    logic                 done_q;

    logic                cur_valid, nxt_valid;
    logic [BufWidth-1:0] cur_data, nxt_data;
    logic [1:0]          retire;

    logic [OffW-1:0]         lane_lo;
    logic [NbW-1:0]          avail, nb;
    logic [PtrW-1:0]         sum;
    logic                    span, beat_ok, last, beat_hs, last_hs, desc_hs;
    logic [BusBytes-1:0]     lane_mask, beat_strb;
    logic [AxiDataWidth-1:0] raw, shifted, beat_data;

    assign txn_in = '{off: txn_off_i, bytes: txn_bytes_i, len: txn_len_i};

    m_store_entry_fifo #(.Width(BufWidth)) u_entry_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .in_valid  (rx_valid_i),
        .in_ready  (rx_ready_o),
        .in_data   (rx_data_i),
        .retire    (retire),
        .cur_valid (cur_valid),
        .cur_data  (cur_data),
        .nxt_valid (nxt_valid),
        .nxt_data  (nxt_data)
    );

    // Beat shape comes only from registered state, so valid never depends on ready.
    assign lane_lo = first_q ? off_q : '0;
    assign avail   = NbW'(BusBytes) - {1'b0, lane_lo};
    assign nb      = (rem_q < TxnBytesW'(avail)) ? NbW'(rem_q) : avail;
    assign sum     = ptr_q + PtrW'(nb);
    assign span    = sum > PtrW'(BufBytes);
    assign beat_ok = (state_q == ST_ACTIVE) && (beats_q != 9'd0) &&
                     ((nb == '0) || (cur_valid && (!span || nxt_valid)));
    assign last    = (beats_q == 9'd1);
    assign beat_hs = beat_ok && axi_w_ready_i;
    assign last_hs = beat_hs && last;

    assign txn_ctrl_ready_o = (state_q == ST_IDLE) || last_hs;
    assign desc_hs          = txn_ctrl_valid_i && txn_ctrl_ready_o;

    always_comb begin
        lane_mask = nb[NbW-1] ? '1 : ((BusBytes'(1) << nb[OffW-1:0]) - BusBytes'(1));
        beat_strb = lane_mask << lane_lo;
        raw       = AxiDataWidth'({nxt_data, cur_data} >> {ptr_q, 3'b000});
        shifted   = raw << {lane_lo, 3'b000};
        beat_data = '0;
        for (int i = 0; i < BusBytes; i++) begin
            beat_data[8*i +: 8] = beat_strb[i] ? shifted[8*i +: 8] : 8'h00;
        end
    end

    // At burst end every touched entry is dropped, including an nxt the last beat reached into.
    always_comb begin
        retire = 2'd0;
        if (beat_hs) begin
            if (last) begin
                retire = (sum == '0) ? 2'd0 : (span ? 2'd2 : 2'd1);
            end else if (sum >= PtrW'(BufBytes)) begin
                retire = 2'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (desc_hs) state_d = ST_ACTIVE;
            ST_ACTIVE: if (last_hs && !desc_hs) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            off_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            ptr_q   <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (desc_hs) begin
                off_q   <= txn_in.off;
                rem_q   <= TxnBytesW'(txn_in.bytes);
                beats_q <= {1'b0, txn_in.len} + 9'd1;
                ptr_q   <= '0;
                first_q <= 1'b1;
            end else if (beat_hs) begin
                rem_q   <= rem_q - TxnBytesW'(nb);
                beats_q <= beats_q - 9'd1;
                first_q <= 1'b0;
                if (last) begin
                    ptr_q <= '0;
                end else if (sum >= PtrW'(BufBytes)) begin
                    ptr_q <= sum - PtrW'(BufBytes);
                end else begin
                    ptr_q <= sum;
                end
            end
        end
    end

    assign axi_w_valid_o = beat_ok;
    assign axi_w_data_o  = beat_ok ? beat_data : '0;
    assign axi_w_strb_o  = beat_ok ? beat_strb : '0;
    assign axi_w_last_o  = beat_ok && last;
    assign store_done_o  = done_q;

endmodule

// File: tb/tb_m_store_seq_pack.sv
// Directed bench for m_store_seq_pack: table of bursts plus hand-written corner sequences.
module tb_m_store_seq_pack;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         txn_valid = 1'b0;
    logic         txn_ready;
    logic [3:0]   txn_off = '0;
    logic [15:0]  txn_bytes = '0;
    logic [7:0]   txn_len = '0;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [511:0] rx_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b1;
    logic [127:0] w_data;
    logic [15:0]  w_strb;
    logic         w_last;
    logic         done;

    always #5 clk = ~clk;

    m_store_seq_pack dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .txn_ctrl_valid_i (txn_valid),
        .txn_ctrl_ready_o (txn_ready),
        .txn_off_i        (txn_off),
        .txn_bytes_i      (txn_bytes),
        .txn_len_i        (txn_len),
        .rx_valid_i       (rx_valid),
        .rx_ready_o       (rx_ready),
        .rx_data_i        (rx_data),
        .axi_w_valid_o    (w_valid),
        .axi_w_ready_i    (w_ready),
        .axi_w_data_o     (w_data),
        .axi_w_strb_o     (w_strb),
        .axi_w_last_o     (w_last),
        .store_done_o     (done)
    );

    typedef struct {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
        int           cyc;
    } beat_t;

    typedef struct {
        logic [3:0]  off;
        logic [15:0] bytes;
        logic [7:0]  len;
        int          n_ent;
        logic [7:0]  tag;
        bit          tog;
        int          n_beats;
        int          idx;
    } vec_t;

    typedef struct {
        logic [15:0] strb;
        int          g0;
        logic        last;
    } eb_t;

    beat_t        got_q[$];
    logic [511:0] rx_q[$];
    int  cyc = 0, done_cnt = 0, done_cyc = -1, desc_cnt = 0, desc_cyc = -1;
    int  n_chk = 0, n_pass = 0;
    bit  toggle_mode = 1'b0, stall_prev = 1'b0, rx_hs_p = 1'b0;
    logic [127:0] st_data;
    logic [15:0]  st_strb;
    logic         st_last;

    vec_t vecs[5];
    eb_t  eb[19];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [511:0] make_entry(input logic [7:0] tag, input int e);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = tag + 8'(e*64 + k);
        return r;
    endfunction

    // Lanes with strobe set carry consecutive stream bytes starting at g0 in the lowest set lane.
    function automatic logic [127:0] exp_data(input logic [7:0] tag, input logic [15:0] strb, input int g0);
        logic [127:0] d;
        int lo;
        d = '0;
        lo = -1;
        for (int i = 0; i < 16; i++) begin
            if (strb[i]) begin
                if (lo < 0) lo = i;
                d[8*i +: 8] = tag + 8'(g0 + i - lo);
            end
        end
        return d;
    endfunction

    // Monitor/feeder: sample away from posedge, update stimulus just after it.
    initial forever begin
        @(negedge clk);
        cyc++;
        rx_hs_p = rx_valid && rx_ready && rst_n;
        if (rst_n) begin
            if (stall_prev) begin
                chk("stall_valid", 128'(w_valid), 128'(1));
                chk("stall_data", w_data, st_data);
                chk("stall_strb", 128'(w_strb), 128'(st_strb));
                chk("stall_last", 128'(w_last), 128'(st_last));
            end
            stall_prev = w_valid && !w_ready;
            st_data = w_data;
            st_strb = w_strb;
            st_last = w_last;
            if (w_valid && w_ready) got_q.push_back('{w_data, w_strb, w_last, cyc});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (txn_valid && txn_ready) begin
                desc_cnt++;
                desc_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rx_hs_p && rx_q.size() > 0) void'(rx_q.pop_front());
        rx_valid = (rx_q.size() > 0);
        rx_data  = rx_valid ? rx_q[0] : '0;
        w_ready  = toggle_mode ? !w_ready : 1'b1;
    end

    task automatic send_desc(input logic [3:0] off, input logic [15:0] bytes, input logic [7:0] len);
        int d0;
        @(posedge clk);
        #2;
        txn_off = off;
        txn_bytes = bytes;
        txn_len = len;
        txn_valid = 1'b1;
        d0 = desc_cnt;
        for (int t = 0; t < 100 && desc_cnt == d0; t++) begin
            @(posedge clk);
            #2;
        end
        txn_valid = 1'b0;
        if (desc_cnt == d0) chk("desc_accept_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_done(input int target);
        for (int t = 0; t < 400 && done_cnt < target; t++) begin
            @(posedge clk);
            #2;
        end
        if (done_cnt < target) chk("done_timeout", 128'(done_cnt), 128'(target));
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic run_burst(input vec_t v, input int vi);
        int d0;
        got_q.delete();
        d0 = done_cnt;
        for (int e = 0; e < v.n_ent; e++) rx_q.push_back(make_entry(v.tag, e));
        toggle_mode = v.tog;
        send_desc(v.off, v.bytes, v.len);
        wait_done(d0 + 1);
        toggle_mode = 1'b0;
        chk($sformatf("v%0d_beat_count", vi), 128'(got_q.size()), 128'(v.n_beats));
        for (int b = 0; b < v.n_beats && b < got_q.size(); b++) begin
            chk($sformatf("v%0d_b%0d_strb", vi, b), 128'(got_q[b].strb), 128'(eb[v.idx+b].strb));
            chk($sformatf("v%0d_b%0d_data", vi, b), got_q[b].data,
                exp_data(v.tag, eb[v.idx+b].strb, eb[v.idx+b].g0));
            chk($sformatf("v%0d_b%0d_last", vi, b), 128'(got_q[b].last), 128'(eb[v.idx+b].last));
        end
        chk($sformatf("v%0d_done_count", vi), 128'(done_cnt - d0), 128'(1));
        if (got_q.size() > 0)
            chk($sformatf("v%0d_done_timing", vi), 128'(done_cyc), 128'(got_q[$].cyc + 1));
        chk($sformatf("v%0d_entries_used", vi), 128'(rx_q.size()), 128'(0));
    endtask

    initial begin
        int d0, dc;
        eb = '{
            '{16'hFFFF, 0, 1'b0}, '{16'hFFFF, 16, 1'b0}, '{16'hFFFF, 32, 1'b0}, '{16'hFFFF, 48, 1'b1},
            '{16'hFFF0, 0, 1'b0}, '{16'hFFFF, 12, 1'b0}, '{16'h000F, 28, 1'b1},
            '{16'hFF00, 0, 1'b0}, '{16'hFFFF, 8, 1'b0}, '{16'hFFFF, 24, 1'b0}, '{16'hFFFF, 40, 1'b0},
            '{16'hFFFF, 56, 1'b0}, '{16'hFFFF, 72, 1'b0}, '{16'hFFFF, 88, 1'b0}, '{16'hFFFF, 104, 1'b0},
            '{16'h00FF, 120, 1'b1},
            '{16'hFFFF, 0, 1'b0}, '{16'h0000, 0, 1'b0}, '{16'h0000, 0, 1'b1}
        };
        vecs = '{
            '{4'd0, 16'd64,  8'd3, 1, 8'h10, 1'b0, 4, 0},
            '{4'd4, 16'd32,  8'd2, 1, 8'h20, 1'b0, 3, 4},
            '{4'd8, 16'd128, 8'd8, 2, 8'h30, 1'b0, 9, 7},
            '{4'd0, 16'd64,  8'd3, 1, 8'h50, 1'b1, 4, 0},
            '{4'd0, 16'd16,  8'd2, 1, 8'h60, 1'b0, 3, 16}
        };

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_txn_ready", 128'(txn_ready), 128'(1));
        chk("rst_rx_ready", 128'(rx_ready), 128'(1));
        chk("rst_w_valid", 128'(w_valid), 128'(0));
        chk("rst_w_strb", 128'(w_strb), 128'(0));
        chk("rst_w_data", w_data, 128'(0));
        chk("rst_w_last", 128'(w_last), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) run_burst(vecs[v], v);

        // Back-to-back descriptors: B must be taken in A's last-beat cycle.
        got_q.delete();
        d0 = done_cnt;
        rx_q.push_back(make_entry(8'h40, 0));
        rx_q.push_back(make_entry(8'h80, 0));
        send_desc(4'd0, 16'd20, 8'd1);
        txn_off = 4'd0;
        txn_bytes = 16'd16;
        txn_len = 8'd0;
        txn_valid = 1'b1;
        dc = desc_cnt;
        for (int t = 0; t < 100 && desc_cnt == dc; t++) begin
            @(posedge clk);
            #2;
        end
        txn_valid = 1'b0;
        if (desc_cnt == dc) chk("b2b_desc_timeout", 128'(0), 128'(1));
        wait_done(d0 + 2);
        chk("b2b_beat_count", 128'(got_q.size()), 128'(3));
        if (got_q.size() == 3) begin
            chk("b2b_a0_strb", 128'(got_q[0].strb), 128'(16'hFFFF));
            chk("b2b_a0_data", got_q[0].data, exp_data(8'h40, 16'hFFFF, 0));
            chk("b2b_a1_strb", 128'(got_q[1].strb), 128'(16'h000F));
            chk("b2b_a1_data", got_q[1].data, exp_data(8'h40, 16'h000F, 16));
            chk("b2b_a1_last", 128'(got_q[1].last), 128'(1));
            chk("b2b_b_accept_cycle", 128'(desc_cyc), 128'(got_q[1].cyc));
            chk("b2b_b0_strb", 128'(got_q[2].strb), 128'(16'hFFFF));
            chk("b2b_b0_data", got_q[2].data, exp_data(8'h80, 16'hFFFF, 0));
            chk("b2b_b0_last", 128'(got_q[2].last), 128'(1));
        end
        chk("b2b_done_count", 128'(done_cnt - d0), 128'(2));
        chk("b2b_entries_used", 128'(rx_q.size()), 128'(0));

        // Reset in the middle of a burst, then rerun a clean burst.
        got_q.delete();
        d0 = done_cnt;
        rx_q.push_back(make_entry(8'h70, 0));
        send_desc(4'd0, 16'd64, 8'd3);
        for (int t = 0; t < 100 && got_q.size() < 2; t++) begin
            @(posedge clk);
            #2;
        end
        chk("mid_rst_two_beats", 128'(got_q.size()), 128'(2));
        rst_n = 1'b0;
        rx_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_w_valid", 128'(w_valid), 128'(0));
        chk("mid_rst_w_last", 128'(w_last), 128'(0));
        chk("mid_rst_done", 128'(done), 128'(0));
        chk("mid_rst_txn_ready", 128'(txn_ready), 128'(1));
        chk("mid_rst_rx_ready", 128'(rx_ready), 128'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        chk("mid_rst_no_done", 128'(done_cnt - d0), 128'(0));
        chk("mid_rst_no_beats", 128'(got_q.size()), 128'(2));
        run_burst(vecs[0], 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
